fir_decim_buf: RTL and testbench
================================

# fir_decim_buf

Downstream stage of `fir_16tap`: consumes the filter's 16-bit Q1.15 output stream, decimates it by a power-of-two factor using a boxcar average, and buffers the decimated samples in a small first-word-fall-through FIFO. The FIFO drains to the next consumer over a valid/ready handshake. A sticky overflow flag reports samples dropped because the FIFO was full.

## Interface
- `LOG2_DECIM`, 2, log2 of the decimation factor; `DECIM = 2**LOG2_DECIM`; legal range 1..4.
- `DEPTH`, 8, FIFO depth in samples; power of two, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `y_in` in 16: signed Q1.15 sample, driven directly from `fir_16tap.y_out`.
- `in_en` in 1: qualifies `y_in`; a sample is accepted on each edge with `in_en=1`.
- `m_data` out 16: signed Q1.15 decimated sample at the FIFO head.
- `m_valid` out 1: FIFO non-empty.
- `m_ready` in 1: consumer accepts `m_data` on an edge with `m_valid & m_ready`.
- `level` out `$clog2(DEPTH)+1`: current FIFO occupancy, 0..DEPTH.
- `ovf` out 1: sticky overflow flag.
- `ovf_clr` in 1: synchronous clear of `ovf`.

## Operation
- Accumulator `acc`: signed, `16+LOG2_DECIM` bits. Phase counter `phase`: runs 0..DECIM-1.
- Accepted sample with `phase<DECIM-1`: `acc <= acc + y_in`, `phase <= phase+1`.
- Accepted sample with `phase==DECIM-1`: block completes.
  - `sum = acc + y_in`.
  - `avg = sum >>> LOG2_DECIM`. This is an arithmetic shift (floor toward −∞), with no rounding. The result always fits in 16 bits, so no saturation is needed.
  - `avg` is pushed to the FIFO.
  - `acc <= 0`, `phase <= 0`.
- `in_en=0`: `acc` and `phase` hold. Gaps within a block are allowed.
- Push when full: the sample is dropped and `ovf <= 1`.
  - Exception: if a pop happens on the same edge, the push succeeds and `level` stays at DEPTH.
- Pop: occurs on `m_valid & m_ready`. `rd_ptr` advances and `level` decrements.
- Simultaneous push and pop when not full: `level` is unchanged and both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
- `m_data` shows `mem[rd_ptr]` when `m_valid=1`, and 0 when empty. Memory contents are never visible while empty.
- `ovf_clr`:
  - `ovf_clr=1` clears `ovf` on that edge.
  - If an overflow drop happens on the same edge, set wins and `ovf` stays 1.
- Reset (async, at any time, including mid-block or mid-drain):
  - `acc=0`, `phase=0`, pointers 0.
  - `level=0`, `m_valid=0`, `m_data=0`, `ovf=0`.
  - Partial blocks are discarded. FIFO memory is not reset.

## Timing
- The DECIM-th accepted sample is at edge N. Its average is at the FIFO head with `m_valid=1` after edge N, provided the FIFO was empty. Latency: one cycle from the completing sample.
- `m_valid`, `level`, and `ovf` are registered. `m_data` is combinational from the registered `rd_ptr` and memory.
- A sample may be pushed and popped in consecutive cycles. Sustained throughput is one output per DECIM accepted inputs; the FIFO never stalls the input side.
- Consumer contract: `m_data` is stable while `m_valid=1` and `m_ready=0`.

## Configuration
- `FIR_DEC_PEAK_EN` defined:
  - Adds output `peak_abs`, 16-bit unsigned, and input `peak_clr`.
  - On every successful push, `peak_abs <= max(peak_abs, |avg|)`. The value −32768 maps to 32768.
  - `peak_clr` sets `peak_abs` to 0 synchronously. A push on the same edge loads `|avg|`.
  - Reset value of `peak_abs` is 0. Dropped (overflow) samples do not update it.
- `FIR_DEC_PEAK_EN` undefined: neither port exists and no peak logic is built. All other behaviour is identical.

## Test plan
- Basic average, LOG2_DECIM=2, `m_ready=1`, `in_en=1`: feed 100, 200, 300, 400 → one output of 250, `m_valid` high exactly one cycle after the 4th sample, `level` returns to 0.
- Negative floor: feed −1, −1, −1, −2 → sum −5 → output −2. Then feed 32767 ×4 → 32767. Then −32768 ×4 → −32768.
- FIR impulse chain: drive `fir_16tap` with 16384 then zeros, and connect `in_en` high after the FIR pipeline fills. The first block 256, 512, 1024, 2048 gives 960. The next block 4096, 2048, 1024, 512 gives 1920.
- Overflow: `m_ready=0`, DEPTH=8, push 9 blocks → `level=8` and `ovf=1` after the 9th. Drain with `m_ready=1` → exactly the first 8 averages appear, in order. Pulse `ovf_clr` → `ovf=0`.
- Full-boundary simultaneity: with `level=8`, complete a block on the same edge as a pop → `level` stays 8, `ovf` stays 0, and the new sample appears last. Also assert `ovf_clr` on an overflow edge → `ovf` stays 1.
- Reset mid-operation: feed 2 of 4 samples with 3 entries queued, then pulse `rst` between edges → `m_valid`, `level`, and `m_data` go to 0 immediately. Then feed 8, 8, 8, 8 → output 8, with no remnant of the pre-reset partial sum. With `FIR_DEC_PEAK_EN` defined, `peak_abs` is 0 after reset and 8 after the block.

Source files
------------

// File: rtl/fir_decim_buf.sv
// Boxcar decimator (factor 2**LOG2_DECIM) feeding a first-word-fall-through FIFO with a sticky overflow flag.
// Optional macro FIR_DEC_PEAK_EN adds a running peak |avg| tracker (peak_abs / peak_clr).
module fir_decim_buf #(
  parameter int unsigned LOG2_DECIM = 2,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [15:0]        y_in,
  input  logic                      in_en,
  output logic signed [15:0]        m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf,
  input  logic                      ovf_clr
`ifdef FIR_DEC_PEAK_EN
  ,
  output logic [15:0]               peak_abs,
  input  logic                      peak_clr
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned ACCW = 16 + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] PH_LAST = '1;

  generate
    if (LOG2_DECIM < 1 || LOG2_DECIM > 4) begin : g_bad_decim
      $error("fir_decim_buf: LOG2_DECIM must be 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fir_decim_buf: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic signed [ACCW-1:0]   acc;
  logic [LOG2_DECIM-1:0]    phase;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic signed [15:0]       mem [DEPTH];

  logic signed [ACCW-1:0]   sum;
  logic signed [15:0]       avg;
  logic                     blk_done;
  logic                     full;
  logic                     pop;
  logic                     push_ok;
  logic                     drop;
  logic [LW-1:0]            level_next;

  // Block accumulation, FIFO push/pop qualification and next occupancy.
  always_comb begin
    sum        = acc + ACCW'(y_in);
    // Low 16 bits of sum >>> LOG2_DECIM: floor division, always in range.
    avg        = sum[LOG2_DECIM +: 16];
    blk_done   = in_en && (phase == PH_LAST);
    full       = (level == LW'(DEPTH));
    pop        = m_valid && m_ready;
    push_ok    = blk_done && (!full || pop);
    drop       = blk_done && full && !pop;
    level_next = level;
    if (push_ok && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push_ok) begin
      level_next = level - LW'(1);
    end
  end

  // Control state: accumulator, phase, pointers, occupancy and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      phase   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      m_valid <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (in_en) begin
        if (blk_done) begin
          acc   <= '0;
          phase <= '0;
        end else begin
          acc   <= sum;
          phase <= phase + LOG2_DECIM'(1);
        end
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level   <= level_next;
      m_valid <= (level_next != '0);
      // A drop on the same edge as a clear keeps the flag set.
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Sample storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= avg;
    end
  end

  assign m_data = m_valid ? mem[rd_ptr] : 16'sd0;

`ifdef FIR_DEC_PEAK_EN
  logic [15:0] avg_abs;

  // Magnitude in 16-bit unsigned; -32768 wraps to 16'h8000 = 32768.
  always_comb begin
    avg_abs = avg[15] ? 16'(-avg) : 16'(avg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_abs <= '0;
    end else if (peak_clr) begin
      peak_abs <= push_ok ? avg_abs : 16'd0;
    end else if (push_ok && (avg_abs > peak_abs)) begin
      peak_abs <= avg_abs;
    end
  end
`endif

endmodule

// File: tb/tb_fir_decim_buf.sv
// Directed self-checking bench for fir_decim_buf (LOG2_DECIM=2, DEPTH=8).
module tb_fir_decim_buf;

  localparam int unsigned LOG2_DECIM = 2;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned DECIM      = 1 << LOG2_DECIM;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] y_in;
  logic               in_en;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic [3:0]         level;
  logic               ovf;
  logic               ovf_clr;
`ifdef FIR_DEC_PEAK_EN
  logic [15:0]        peak_abs;
  logic               peak_clr;
`endif

  int vectors = 0;
  int errors  = 0;

  fir_decim_buf #(.LOG2_DECIM(LOG2_DECIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .in_en(in_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef FIR_DEC_PEAK_EN
    , .peak_abs(peak_abs), .peak_clr(peak_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic signed [15:0] s);
    y_in  = s;
    in_en = 1'b1;
    step();
    in_en = 1'b0;
    y_in  = '0;
  endtask

  task automatic push_block(input logic signed [15:0] s);
    for (int i = 0; i < int'(DECIM); i++) feed(s);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_en = 1'b0; y_in = '0; m_ready = 1'b0; ovf_clr = 1'b0;
`ifdef FIR_DEC_PEAK_EN
    peak_clr = 1'b0;
`endif
    step(); step();
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    vectors++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    vectors++; if (m_data !== 16'sd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", m_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_avg();
    m_ready = 1'b1;
    feed(16'sd100); feed(16'sd200); feed(16'sd300);
    vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", m_valid); end
    feed(16'sd400);
    vectors++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", m_valid); end
    vectors++; if (m_data !== 16'sd250) begin errors++; $display("FAIL basic_data got=%0d exp=250", m_data); end
    vectors++; if (level !== 4'd1) begin errors++; $display("FAIL basic_level got=%0d exp=1", level); end
    step();
    vectors++; if (level !== 4'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got level=%0d valid=%b exp 0/0", level, m_valid); end
    vectors++; if (m_data !== 16'sd0) begin errors++; $display("FAIL basic_empty_data got=%0d exp=0", m_data); end
  endtask

  task automatic test_neg_floor();
    m_ready = 1'b1;
    feed(-16'sd1); feed(-16'sd1); feed(-16'sd1); feed(-16'sd2);
    vectors++; if (m_data !== -16'sd2) begin errors++; $display("FAIL floor_neg got=%0d exp=-2", m_data); end
    step();
    push_block(16'sd32767);
    vectors++; if (m_data !== 16'sd32767) begin errors++; $display("FAIL pos_max got=%0d exp=32767", m_data); end
    step();
    push_block(-16'sd32768);
    vectors++; if (m_data !== -16'sd32768) begin errors++; $display("FAIL neg_max got=%0d exp=-32768", m_data); end
    step();
`ifdef FIR_DEC_PEAK_EN
    vectors++; if (peak_abs !== 16'd32768) begin errors++; $display("FAIL peak_neg_max got=%0d exp=32768", peak_abs); end
`endif
  endtask

  task automatic test_fir_chain();
    m_ready = 1'b1;
    feed(16'sd256); feed(16'sd512); feed(16'sd1024); feed(16'sd2048);
    vectors++; if (m_data !== 16'sd960) begin errors++; $display("FAIL fir_blk0 got=%0d exp=960", m_data); end
    feed(16'sd4096);
    feed(16'sd2048); feed(16'sd1024); feed(16'sd512);
    vectors++; if (m_data !== 16'sd1920) begin errors++; $display("FAIL fir_blk1 got=%0d exp=1920", m_data); end
    step();
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) push_block(16'(1000 + k));
    vectors++; if (level !== 4'd8 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_fill got level=%0d ovf=%b exp 8/0", level, ovf); end
    push_block(16'sd1008);
    vectors++; if (level !== 4'd8 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got level=%0d ovf=%b exp 8/1", level, ovf); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 16'(1000 + i)) begin
        errors++; $display("FAIL ovf_drain%0d got valid=%b data=%0d exp 1/%0d", i, m_valid, m_data, 1000 + i);
      end
      step();
    end
    vectors++; if (m_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL ovf_empty got valid=%b level=%0d exp 0/0", m_valid, level); end
    vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_full_boundary();
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) push_block(16'(2000 + k));
    feed(16'sd2008); feed(16'sd2008); feed(16'sd2008);
    m_ready = 1'b1;
    feed(16'sd2008);
    m_ready = 1'b0;
    vectors++; if (level !== 4'd8 || ovf !== 1'b0) begin errors++; $display("FAIL full_pushpop got level=%0d ovf=%b exp 8/0", level, ovf); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 16'(2001 + i)) begin
        errors++; $display("FAIL full_order%0d got valid=%b data=%0d exp 1/%0d", i, m_valid, m_data, 2001 + i);
      end
      step();
    end
    vectors++; if (level !== 4'd0) begin errors++; $display("FAIL full_empty got=%0d exp=0", level); end
    // Clear coincident with a drop: the drop must win.
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) push_block(16'(3000 + k));
    feed(16'sd3008); feed(16'sd3008); feed(16'sd3008);
    ovf_clr = 1'b1;
    feed(16'sd3008);
    ovf_clr = 1'b0;
    vectors++; if (ovf !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL set_wins got ovf=%b level=%0d exp 1/8", ovf, level); end
    m_ready = 1'b1;
    repeat (8) step();
    vectors++; if (level !== 4'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL set_wins_drain got level=%0d valid=%b exp 0/0", level, m_valid); end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    push_block(16'sd5); push_block(16'sd6); push_block(16'sd7);
    vectors++; if (level !== 4'd3) begin errors++; $display("FAIL mid_queued got=%0d exp=3", level); end
    feed(16'sd100); feed(16'sd100);
    rst = 1'b1;
    #1;
    vectors++; if (m_valid !== 1'b0 || level !== 4'd0 || m_data !== 16'sd0) begin
      errors++; $display("FAIL mid_async got valid=%b level=%0d data=%0d exp 0/0/0", m_valid, level, m_data);
    end
`ifdef FIR_DEC_PEAK_EN
    vectors++; if (peak_abs !== 16'd0) begin errors++; $display("FAIL mid_peak_rst got=%0d exp=0", peak_abs); end
`endif
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    push_block(16'sd8);
    vectors++; if (m_valid !== 1'b1 || m_data !== 16'sd8 || level !== 4'd1) begin
      errors++; $display("FAIL mid_after got valid=%b data=%0d level=%0d exp 1/8/1", m_valid, m_data, level);
    end
`ifdef FIR_DEC_PEAK_EN
    vectors++; if (peak_abs !== 16'd8) begin errors++; $display("FAIL mid_peak got=%0d exp=8", peak_abs); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_basic_avg();
    test_neg_floor();
    test_fir_chain();
    test_overflow();
    test_full_boundary();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
